shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_if.sv | 15 +
 rtl/shift_add_mult_ctrl.sv | 55 +++++
 tb/tb_shift_add_mult_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand/strobe bundle between a requester and the shift-add multiply controller
interface shift_add_mult_if #(parameter int WL = 4);
   localparam int CW = $clog2(WL + 1);
   logic start;
   logic [WL-1:0] a;
   logic [WL-1:0] b;
   logic busy;
   logic done;
   logic [2*WL-1:0] product;
   logic sr_load;
   logic sr_shift;
   logic [CW-1:0] count;
   modport master(output start, a, b, input busy, done, product, sr_load, sr_shift, count);
   modport slave(input start, a, b, output busy, done, product, sr_load, sr_shift, count);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: fixed-latency shift-and-add unsigned multiplier with strobes for an external shift register
module shift_add_mult_ctrl #(parameter int WL = 4) (
   input logic clk,
   input logic rst,
   shift_add_mult_if.slave bus
);
   localparam int CW = $clog2(WL + 1);
   localparam logic [CW-1:0] LAST = CW'(WL - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [2*WL-1:0] mcand, acc, acc_nxt, prod;
   logic [WL-1:0] mplier;
   logic [CW-1:0] cnt;
   logic hold, accept;
   // hold masks the IDLE cycle right after DONE, spacing back-to-back operations WL+3 cycles apart
   assign accept = !rst && state == IDLE && bus.start && !hold;
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb
      nxt = state == IDLE ? (accept ? RUN : IDLE) :
            state == RUN  ? (cnt == LAST ? DONE : RUN) : IDLE;
   always_comb begin
      bus.busy = state == RUN || state == DONE;
      bus.done = state == DONE;
      bus.sr_load = accept;
      bus.sr_shift = state == RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
         prod <= '0;
         cnt <= '0;
         hold <= 1'b0;
      end else begin
         hold <= state == DONE;
         if (accept) begin
            mcand <= {{WL{1'b0}}, bus.a};
            mplier <= bus.b;
            acc <= '0;
            cnt <= '0;
         end else if (state == RUN) begin
            acc <= acc_nxt;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) prod <= acc_nxt;
         end
      end
   end
   assign bus.product = prod;
   assign bus.count = cnt;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: scenario tasks plus a done-driven scoreboard for the shift-add multiply controller
module tb_shift_add_mult_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int ntests = 0;
   int nfail = 0;
   logic [7:0] q[$];
   logic [7:0] exp_p;
   always #5 clk = ~clk;
   shift_add_mult_if #(.WL(4)) bus();
   shift_add_mult_if #(.WL(8)) bus8();
   shift_add_mult_ctrl #(.WL(4)) dut(.clk(clk), .rst(rst), .bus(bus));
   shift_add_mult_ctrl #(.WL(8)) dut8(.clk(clk), .rst(rst), .bus(bus8));
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         ntests++;
         if (q.size() == 0) begin
            nfail++;
            $display("FAIL sb_unexpected_done product=%0d required=none", bus.product);
         end else begin
            exp_p = q.pop_front();
            if (bus.product !== exp_p) begin
               nfail++;
               $display("FAIL sb_product got=%0d required=%0d", bus.product, exp_p);
            end
         end
      end
   end
   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      repeat (2) @(negedge clk);
      ntests++;
      if ({bus.busy, bus.done, bus.sr_load, bus.sr_shift} !== 4'b0000 || bus.product !== 8'd0 || bus.count !== 3'd0) begin
         nfail++;
         $display("FAIL reset flags=%b product=%0d count=%0d required=0000/0/0",
                  {bus.busy, bus.done, bus.sr_load, bus.sr_shift}, bus.product, bus.count);
      end
      bus.start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic test_basic;
      logic [3:0] want;
      @(negedge clk);
      bus.a = 4'd3; bus.b = 4'd5; bus.start = 1'b1;
      q.push_back(8'd15);
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) begin
            @(negedge clk);
            bus.start = 1'b0;
         end
         #1;
         want = k == 0 ? 4'b1000 : k <= 4 ? 4'b0110 : k == 5 ? 4'b0011 : 4'b0000;
         ntests++;
         if ({bus.sr_load, bus.sr_shift, bus.busy, bus.done} !== want) begin
            nfail++;
            $display("FAIL basic_cycle%0d load/shift/busy/done=%b required=%b", k,
                     {bus.sr_load, bus.sr_shift, bus.busy, bus.done}, want);
         end
         if (k >= 1 && k <= 5) begin
            ntests++;
            if (bus.count !== 3'(k - 1)) begin
               nfail++;
               $display("FAIL basic_count cycle%0d got=%0d required=%0d", k, bus.count, k - 1);
            end
         end
      end
   endtask
   task automatic test_values;
      logic [3:0] av[4] = '{4'd15, 4'd0, 4'd7, 4'd12};
      logic [3:0] bv[4] = '{4'd15, 4'd9, 4'd1, 4'd10};
      for (int i = 0; i < 6; i++) begin
         logic [3:0] ta, tb;
         ta = i < 4 ? av[i] : 4'($urandom_range(0, 15));
         tb = i < 4 ? bv[i] : 4'($urandom_range(0, 15));
         repeat (2) @(negedge clk);
         bus.a = ta; bus.b = tb; bus.start = 1'b1;
         q.push_back(8'(ta) * 8'(tb));
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 2) begin bus.a = ~ta; bus.b = ~tb; end
            ntests++;
            if (bus.done !== (k == 5)) begin
               nfail++;
               $display("FAIL values_done op%0d cycle%0d got=%b required=%b", i, k, bus.done, k == 5);
            end
         end
      end
   endtask
   task automatic test_ignore_busy;
      int pulses = 0;
      repeat (2) @(negedge clk);
      bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
      q.push_back(8'd42);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         bus.start = k >= 2 && k <= 5;
         if (k >= 2) begin bus.a = 4'd2; bus.b = 4'd2; end
         if (bus.done) pulses++;
         ntests++;
         if (bus.done !== (k == 5)) begin
            nfail++;
            $display("FAIL ignore_done cycle%0d got=%b required=%b", k, bus.done, k == 5);
         end
      end
      ntests++;
      if (pulses != 1) begin
         nfail++;
         $display("FAIL ignore_pulses got=%0d required=1", pulses);
      end
      bus.start = 1'b0;
   endtask
   task automatic test_back_to_back;
      repeat (2) @(negedge clk);
      bus.a = 4'd2; bus.b = 4'd3;
      repeat (3) q.push_back(8'd6);
      for (int k = 0; k <= 22; k++) begin
         if (k > 0) @(negedge clk);
         bus.start = k < 20;
         if (k > 0) begin
            ntests++;
            if (bus.done !== (k == 5 || k == 12 || k == 19)) begin
               nfail++;
               $display("FAIL b2b_done cycle%0d got=%b required=%b", k, bus.done, k == 5 || k == 12 || k == 19);
            end
         end
      end
      ntests++;
      if (q.size() != 0) begin
         nfail++;
         $display("FAIL b2b_pending got=%0d required=0", q.size());
      end
      q.delete();
      repeat (8) @(negedge clk);
   endtask
   task automatic test_reset_abort;
      repeat (2) @(negedge clk);
      bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
      q.push_back(8'd81);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      ntests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'd0) begin
         nfail++;
         $display("FAIL abort_state busy=%b done=%b product=%0d required=0/0/0", bus.busy, bus.done, bus.product);
      end
      for (int k = 4; k <= 7; k++) begin
         @(negedge clk);
         ntests++;
         if (bus.done !== 1'b0) begin
            nfail++;
            $display("FAIL abort_done cycle%0d got=%b required=0", k, bus.done);
         end
      end
      bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
      q.push_back(8'd1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         ntests++;
         if (bus.done !== (k == 5)) begin
            nfail++;
            $display("FAIL abort_next_done cycle%0d got=%b required=%b", k, bus.done, k == 5);
         end
      end
   endtask
   task automatic test_wide;
      @(negedge clk);
      bus8.a = 8'd255; bus8.b = 8'd255; bus8.start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus8.start = 1'b0;
         ntests++;
         if (bus8.done !== (k == 9)) begin
            nfail++;
            $display("FAIL wide_done cycle%0d got=%b required=%b", k, bus8.done, k == 9);
         end
         if (k == 9) begin
            ntests++;
            if (bus8.product !== 16'd65025) begin
               nfail++;
               $display("FAIL wide_product got=%0d required=65025", bus8.product);
            end
         end
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_values;
      test_ignore_busy;
      test_back_to_back;
      test_reset_abort;
      test_wide;
      repeat (3) @(negedge clk);
      ntests++;
      if (q.size() != 0) begin
         nfail++;
         $display("FAIL sb_leftover got=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
